pc_ir_unit: RTL and testbench

- Program-counter and instruction-register stage of the multi-cycle datapath.
- Consumes the PC/IR control strobes from the control FSM (PCWrite, PCWriteCond, BranchCond, PCSource, IRWrite) and evaluates branch conditions from ALU flags.
- Holds PC, IR and the memory data register (MDR), and handles the instruction-memory ready handshake.
- Feeds the decoded opcode and instruction fields back upstream to the control and ALU-control logic.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/branch_eval.sv | 26 ++
 rtl/pc_ir_unit.sv | 118 +++++++++++
 tb/tb_pc_ir_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings and field positions for the multi-cycle CPU datapath.
package cpu_pkg;

    // Branch condition selector driven by the control FSM.
    typedef enum logic [1:0] {
        BR_EQ  = 2'b00,   // taken when Zero
        BR_NE  = 2'b01,   // taken when !Zero
        BR_LTZ = 2'b10,   // taken when Neg
        BR_GTZ = 2'b11    // taken when !Neg & !Zero
    } branchCond_e;

    // Next-PC source selector.
    typedef enum logic [1:0] {
        PCS_ALU    = 2'b00,  // combinational ALU result (PC+4)
        PCS_ALUOUT = 2'b01,  // registered ALU output (branch target)
        PCS_JUMP   = 2'b10,  // {PC[31:28], IR[25:0], 00}
        PCS_REG    = 2'b11   // register A (jr)
    } pcSource_e;

    // Instruction field bit positions.
    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int JADDR_MSB  = 25;

    // Sign-extend a 16-bit immediate to the 32-bit datapath.
    function automatic logic [31:0] signExt16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluator: decodes BranchCond against the ALU flags.
module branch_eval
    import cpu_pkg::*;
(
    input  logic [1:0] branchCond,
    input  logic       zero,
    input  logic       neg,
    output logic       condTrue
);

    branchCond_e condSel;
    assign condSel = branchCond_e'(branchCond);

    // Select the flag expression for the requested comparison.
    always_comb begin
        condTrue = 1'b0;
        case (condSel)
            BR_EQ:   condTrue = zero;
            BR_NE:   condTrue = !zero;
            BR_LTZ:  condTrue = neg;
            BR_GTZ:  condTrue = !neg && !zero;
            default: condTrue = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR / MDR stage of the multi-cycle datapath with fetch handshake,
// branch-gated PC loads, misalignment detection and a fetch counter.
module pc_ir_unit
    import cpu_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic [1:0]        BranchCond,
    input  logic [1:0]        PCSource,
    input  logic              IRWrite,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] RegA,
    input  logic              Zero,
    input  logic              Neg,
    input  logic [DATA_W-1:0] MemData,
    input  logic              MemReady,
    output logic [DATA_W-1:0] PC,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] ImmSext,
    output logic [DATA_W-1:0] ImmShift,
    output logic [DATA_W-1:0] MDR,
    output logic              Stall,
    output logic              MisalignFault,
    output logic [CNT_W-1:0]  InstrCount
);

    // Memory handshake: MemReady is the valid for MemData in the same cycle;
    // there is no ready back-pressure. A fetch (IRWrite) without MemReady
    // stalls, freezing PC and IR until the data arrives.
    logic [DATA_W-1:0] pcReg;
    logic [DATA_W-1:0] irReg;
    logic [DATA_W-1:0] mdrReg;
    logic              faultReg;
    logic [CNT_W-1:0]  cntReg;
    logic              condTrue;
    logic              irLd;
    logic              pcLd;
    logic [DATA_W-1:0] pcTarget;
    pcSource_e         pcSel;

    branch_eval uBranchEval (
        .branchCond (BranchCond),
        .zero       (Zero),
        .neg        (Neg),
        .condTrue   (condTrue)
    );

    assign Stall = IRWrite && !MemReady;
    assign irLd  = IRWrite && MemReady;
    assign pcLd  = (PCWrite || (PCWriteCond && condTrue)) && !Stall;
    assign pcSel = pcSource_e'(PCSource);

    // Next-PC mux; the jump target uses the PC and IR before this edge.
    always_comb begin
        pcTarget = ALUResult;
        case (pcSel)
            PCS_ALU:    pcTarget = ALUResult;
            PCS_ALUOUT: pcTarget = ALUOut;
            PCS_JUMP:   pcTarget = {pcReg[31:28], irReg[JADDR_MSB:0], 2'b00};
            PCS_REG:    pcTarget = RegA;
            default:    pcTarget = ALUResult;
        endcase
    end

    // PC register: word-aligned load on pcLd.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)    pcReg <= RESET_PC;
        else if (pcLd) pcReg <= {pcTarget[DATA_W-1:2], 2'b00};
    end

    // Sticky fault when a loaded target had low address bits set.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                          faultReg <= 1'b0;
        else if (pcLd && (pcTarget[1:0] != 2'b00)) faultReg <= 1'b1;
    end

    // Instruction register: captures fetched data on a completed fetch.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)    irReg <= '0;
        else if (irLd) irReg <= MemData;
    end

    // Memory data register: captures any valid memory read.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)        mdrReg <= '0;
        else if (MemReady) mdrReg <= MemData;
    end

    // Fetched-instruction counter, wraps naturally.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)    cntReg <= '0;
        else if (irLd) cntReg <= cntReg + 1'b1;
    end

    assign PC            = pcReg;
    assign MDR           = mdrReg;
    assign MisalignFault = faultReg;
    assign InstrCount    = cntReg;
    assign opcode        = irReg[OP_MSB:OP_LSB];
    assign rs            = irReg[RS_MSB:RS_LSB];
    assign rt            = irReg[RT_MSB:RT_LSB];
    assign rd            = irReg[RD_MSB:RD_LSB];
    assign funct         = irReg[FUNCT_MSB:FUNCT_LSB];
    assign ImmSext       = signExt16(irReg[IMM_MSB:0]);
    assign ImmShift      = {ImmSext[DATA_W-3:0], 2'b00};

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit (instantiated with a 4-bit counter).
module tb_pc_ir_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PCWrite, PCWriteCond, IRWrite, Zero, Neg, MemReady;
    logic [1:0]  BranchCond, PCSource;
    logic [31:0] ALUResult, ALUOut, RegA, MemData;
    logic [31:0] PC, ImmSext, ImmShift, MDR;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic        Stall, MisalignFault;
    logic [3:0]  InstrCount;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    pc_ir_unit #(.DATA_W(32), .RESET_PC(32'h0), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .BranchCond(BranchCond), .PCSource(PCSource), .IRWrite(IRWrite),
        .ALUResult(ALUResult), .ALUOut(ALUOut), .RegA(RegA), .Zero(Zero), .Neg(Neg),
        .MemData(MemData), .MemReady(MemReady), .PC(PC), .opcode(opcode), .rs(rs),
        .rt(rt), .rd(rd), .funct(funct), .ImmSext(ImmSext), .ImmShift(ImmShift),
        .MDR(MDR), .Stall(Stall), .MisalignFault(MisalignFault), .InstrCount(InstrCount)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic        pcW, pcWC;
        logic [1:0]  bc, ps;
        logic        irW, rdy;
        logic [31:0] memData, aluRes, aluOut, regA;
        logic        zero, neg;
        logic        expStall;
        logic [31:0] expPc, expIr, expMdr;
        logic [3:0]  expCnt;
        logic        expFault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic pcW, logic pcWC, logic [1:0] bc,
                                logic [1:0] ps, logic irW, logic rdy, logic [31:0] memData,
                                logic [31:0] aluRes, logic [31:0] aluOut, logic [31:0] regA,
                                logic zero, logic neg, logic expStall, logic [31:0] expPc,
                                logic [31:0] expIr, logic [31:0] expMdr, logic [3:0] expCnt,
                                logic expFault);
        vec_t v;
        v.name = name; v.pcW = pcW; v.pcWC = pcWC; v.bc = bc; v.ps = ps;
        v.irW = irW; v.rdy = rdy; v.memData = memData; v.aluRes = aluRes;
        v.aluOut = aluOut; v.regA = regA; v.zero = zero; v.neg = neg;
        v.expStall = expStall; v.expPc = expPc; v.expIr = expIr; v.expMdr = expMdr;
        v.expCnt = expCnt; v.expFault = expFault;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_ir(input string nm, input logic [31:0] e);
        logic [31:0] sx;
        sx = {{16{e[15]}}, e[15:0]};
        check({nm, ".opcode"}, {26'b0, opcode}, {26'b0, e[31:26]});
        check({nm, ".rs"}, {27'b0, rs}, {27'b0, e[25:21]});
        check({nm, ".rt"}, {27'b0, rt}, {27'b0, e[20:16]});
        check({nm, ".rd"}, {27'b0, rd}, {27'b0, e[15:11]});
        check({nm, ".funct"}, {26'b0, funct}, {26'b0, e[5:0]});
        check({nm, ".ImmSext"}, ImmSext, sx);
        check({nm, ".ImmShift"}, ImmShift, sx << 2);
    endtask

    // driver: apply one vector on the falling edge
    task automatic drive(input vec_t v);
        @(negedge Clk);
        PCWrite = v.pcW; PCWriteCond = v.pcWC; BranchCond = v.bc; PCSource = v.ps;
        IRWrite = v.irW; MemReady = v.rdy; MemData = v.memData; ALUResult = v.aluRes;
        ALUOut = v.aluOut; RegA = v.regA; Zero = v.zero; Neg = v.neg;
    endtask

    task automatic fetch(input logic [31:0] d);
        @(negedge Clk);
        IRWrite = 1'b1; MemReady = 1'b1; MemData = d; PCWrite = 1'b0; PCWriteCond = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        PCWrite = 0; PCWriteCond = 0; BranchCond = 0; PCSource = 0; IRWrite = 0;
        ALUResult = 0; ALUOut = 0; RegA = 0; Zero = 0; Neg = 0; MemData = 0; MemReady = 0;

        //            name        pcW pcWC bc     ps     irW rdy memData       aluRes        aluOut        regA          z  n  stall expPc         expIr         expMdr        cnt fault
        vecs.push_back(mk("fetch0",   1, 0, 2'b00, 2'b00, 1, 1, 32'h2002_0005, 32'h4,        32'h0,        32'h0,        0, 0, 0, 32'h4,        32'h2002_0005, 32'h2002_0005, 1, 0));
        vecs.push_back(mk("stall1",   1, 0, 2'b00, 2'b00, 1, 0, 32'hDEAD_BEEF, 32'h8,        32'h0,        32'h0,        0, 0, 1, 32'h4,        32'h2002_0005, 32'h2002_0005, 1, 0));
        vecs.push_back(mk("stall2",   1, 0, 2'b00, 2'b00, 1, 0, 32'hDEAD_BEEF, 32'h8,        32'h0,        32'h0,        0, 0, 1, 32'h4,        32'h2002_0005, 32'h2002_0005, 1, 0));
        vecs.push_back(mk("stall3",   1, 0, 2'b00, 2'b00, 1, 0, 32'hDEAD_BEEF, 32'h8,        32'h0,        32'h0,        0, 0, 1, 32'h4,        32'h2002_0005, 32'h2002_0005, 1, 0));
        vecs.push_back(mk("unstall",  1, 0, 2'b00, 2'b00, 1, 1, 32'h8C43_FFFC, 32'h8,        32'h0,        32'h0,        0, 0, 0, 32'h8,        32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("beq_tk",   0, 1, 2'b00, 2'b01, 0, 0, 32'h0,         32'h0,        32'h40,       32'h0,        1, 0, 0, 32'h40,       32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("bne_nt",   0, 1, 2'b01, 2'b01, 0, 0, 32'h0,         32'h0,        32'h80,       32'h0,        1, 0, 0, 32'h40,       32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("bgtz_tk",  0, 1, 2'b11, 2'b01, 0, 0, 32'h0,         32'h0,        32'hC0,       32'h0,        0, 0, 0, 32'hC0,       32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("bltz_nt",  0, 1, 2'b10, 2'b01, 0, 0, 32'h0,         32'h0,        32'h100,      32'h0,        0, 0, 0, 32'hC0,       32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("bltz_tk",  0, 1, 2'b10, 2'b01, 0, 0, 32'h0,         32'h0,        32'h100,      32'h0,        0, 1, 0, 32'h100,      32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("bne_tk",   0, 1, 2'b01, 2'b01, 0, 0, 32'h0,         32'h0,        32'h104,      32'h0,        0, 0, 0, 32'h104,      32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("bgtz_nt",  0, 1, 2'b11, 2'b01, 0, 0, 32'h0,         32'h0,        32'h200,      32'h0,        1, 0, 0, 32'h104,      32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("pcw_dom",  1, 1, 2'b00, 2'b01, 0, 0, 32'h0,         32'h0,        32'h300,      32'h0,        0, 0, 0, 32'h300,      32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("cond_stl", 0, 1, 2'b00, 2'b01, 1, 0, 32'h0,         32'h0,        32'h400,      32'h0,        1, 0, 1, 32'h300,      32'h8C43_FFFC, 32'h8C43_FFFC, 2, 0));
        vecs.push_back(mk("mdr_only", 0, 0, 2'b00, 2'b00, 0, 1, 32'h1234_5678, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h300,      32'h8C43_FFFC, 32'h1234_5678, 2, 0));
        vecs.push_back(mk("jr_fetch", 1, 0, 2'b00, 2'b11, 1, 1, 32'h0800_0100, 32'h0,        32'h0,        32'hA000_0010, 0, 0, 0, 32'hA000_0010, 32'h0800_0100, 32'h0800_0100, 3, 0));
        vecs.push_back(mk("j_fetch",  1, 0, 2'b00, 2'b10, 1, 1, 32'h0800_0200, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'hA000_0400, 32'h0800_0200, 32'h0800_0200, 4, 0));
        vecs.push_back(mk("jump",     1, 0, 2'b00, 2'b10, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0, 0, 32'hA000_0800, 32'h0800_0200, 32'h0800_0200, 4, 0));
        vecs.push_back(mk("jr_mis",   1, 0, 2'b00, 2'b11, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0000_1003, 0, 0, 0, 32'h1000,     32'h0800_0200, 32'h0800_0200, 4, 1));
        vecs.push_back(mk("clean1",   1, 0, 2'b00, 2'b00, 0, 0, 32'h0,         32'h2000,     32'h0,        32'h0,        0, 0, 0, 32'h2000,     32'h0800_0200, 32'h0800_0200, 4, 1));
        vecs.push_back(mk("zero_tgt", 1, 0, 2'b00, 2'b00, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0800_0200, 32'h0800_0200, 4, 1));

        // reset release checks
        #12;
        Reset = 1'b1;
        #1;
        check("rst.PC", PC, 32'h0);
        check_ir("rst", 32'h0);
        check("rst.cnt", {28'b0, InstrCount}, 32'h0);
        check("rst.stall", {31'b0, Stall}, 32'h0);
        check("rst.mdr", MDR, 32'h0);
        check("rst.fault", {31'b0, MisalignFault}, 32'h0);

        // table-driven vectors
        foreach (vecs[i]) exp_q.push_back(vecs[i].expPc);
        foreach (vecs[i]) begin
            logic [31:0] ePc;
            drive(vecs[i]);
            #1;
            check({vecs[i].name, ".stall"}, {31'b0, Stall}, {31'b0, vecs[i].expStall});
            @(posedge Clk);
            #1;
            ePc = exp_q.pop_front();
            check({vecs[i].name, ".PC"}, PC, ePc);
            check_ir(vecs[i].name, vecs[i].expIr);
            check({vecs[i].name, ".MDR"}, MDR, vecs[i].expMdr);
            check({vecs[i].name, ".cnt"}, {28'b0, InstrCount}, {28'b0, vecs[i].expCnt});
            check({vecs[i].name, ".fault"}, {31'b0, MisalignFault}, {31'b0, vecs[i].expFault});
        end

        // asynchronous reset asserted mid-stall, away from any clock edge
        @(negedge Clk);
        PCWrite = 1'b1; PCWriteCond = 1'b0; PCSource = 2'b00; ALUResult = 32'h500;
        IRWrite = 1'b1; MemReady = 1'b0;
        #1;
        check("mid.stall_pre", {31'b0, Stall}, 32'h1);
        #1;
        Reset = 1'b0;
        #1;
        check("mid.PC", PC, 32'h0);
        check("mid.fault", {31'b0, MisalignFault}, 32'h0);
        check("mid.cnt", {28'b0, InstrCount}, 32'h0);
        check("mid.mdr", MDR, 32'h0);
        check("mid.opcode", {26'b0, opcode}, 32'h0);
        IRWrite = 1'b0; PCWrite = 1'b0;
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check("rel.stall", {31'b0, Stall}, 32'h0);
        check("rel.PC", PC, 32'h0);

        // counter wrap: 16 fetches return the 4-bit counter to 0
        for (int k = 1; k <= 16; k++) begin
            logic [31:0] d;
            d = 32'h0000_0020 + k;
            fetch(d);
            check($sformatf("wrap%0d.cnt", k), {28'b0, InstrCount}, k % 16);
            check($sformatf("wrap%0d.funct", k), {26'b0, funct}, {26'b0, d[5:0]});
        end
        check("wrap.PC", PC, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
